// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-file constants and helpers for the write-back arbiter.
// Register 0 is hardwired and never appears in a pending mask.
package wb_write_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [NUM_REGS-1:0]   reg_mask_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   // One-hot decode of a destination register; $0 decodes to an empty mask.
   function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
      reg_mask_t m;
      m = '0;
      if (addr != ZERO_REG) m[addr] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular queue of pending MDU results {dest, data}.
// Exposes the head, the occupancy count and a per-slot valid vector.
module wb_result_fifo
   import wb_write_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [REG_ADDR_W-1:0]         push_dest,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [REG_ADDR_W-1:0]         head_dest,
   output logic [DATA_W-1:0]             head_data,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          empty,
   output logic                          full,
   output logic [DEPTH-1:0]              valid,
   output logic [DEPTH*REG_ADDR_W-1:0]   dest_flat
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   reg_addr_t         dest_q [DEPTH];
   reg_addr_t         dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              push_ok, pop_ok;

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == (PTR_W+1)'(DEPTH));
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      dest_d  = dest_q;
      data_d  = data_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) begin
         dest_d[wptr_q] = push_dest;
         data_d[wptr_q] = push_data;
         wptr_d         = wptr_q + 1'b1;
      end
      if (pop_ok) rptr_d = rptr_q + 1'b1;
      if (push_ok && !pop_ok) count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset: the valid vector masks stale slots.
   always_ff @(posedge clk) begin
      dest_q <= dest_d;
      data_q <= data_d;
   end

   always_comb begin
      head_dest = dest_q[rptr_q];
      head_data = data_q[rptr_q];
      count     = count_q;
      valid     = '0;
      dest_flat = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PTR_W'(i) - rptr_q} < count_q);
         dest_flat[i*REG_ADDR_W +: REG_ADDR_W] = dest_q[i];
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port: pipeline WB always wins, queued MDU results
// drain in free slots, and prolonged starvation requests a WB bubble.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned DATA_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mdu_valid,
   input  logic [4:0]        mdu_dest,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [31:0]       pending_mask,
   output logic              stall_req,
   output logic              waw_err
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   reg_addr_t                   head_dest;
   logic [DATA_W-1:0]           head_data;
   logic [$clog2(DEPTH):0]      fifo_count;
   logic                        fifo_empty, fifo_full;
   logic [DEPTH-1:0]            fifo_valid;
   logic [DEPTH*REG_ADDR_W-1:0] fifo_dests;

   logic             wb_busy, push, pop;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             stall_q, stall_d;
   logic             waw_q, waw_d;

   wb_result_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_dest (mdu_dest),
      .push_data (mdu_data),
      .pop       (pop),
      .head_dest (head_dest),
      .head_data (head_data),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .valid     (fifo_valid),
      .dest_flat (fifo_dests)
   );

   always_comb begin
      wb_busy   = wb_reg_write & (wb_dest != ZERO_REG);
      mdu_ready = ~fifo_full;
      push      = mdu_valid & mdu_ready;
      // Draining is suppressed under reset so discarded entries never reach the rf.
      pop       = ~reset & ~wb_busy & ~fifo_empty;
      rf_we     = 1'b0;
      rf_waddr  = ZERO_REG;
      rf_wdata  = '0;
      if (wb_busy) begin
         rf_we    = 1'b1;
         rf_waddr = wb_dest;
         rf_wdata = wb_data;
      end else if (pop) begin
         rf_we    = (head_dest != ZERO_REG);
         rf_waddr = head_dest;
         rf_wdata = head_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i]) pending_mask |= reg_onehot(fifo_dests[i*REG_ADDR_W +: REG_ADDR_W]);
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) starve_d = '0;
      else if (starve_q != CNT_MAX) starve_d = starve_q + 1'b1;
      stall_d = stall_q;
      if (pop) stall_d = 1'b0;
      else if (starve_q == CNT_MAX) stall_d = 1'b1;
      waw_d = waw_q | (wb_busy & pending_mask[wb_dest]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
         stall_q  <= 1'b0;
         waw_q    <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
         waw_q    <= waw_d;
      end
   end

   assign stall_req = stall_q;
   assign waw_err   = waw_q;

endmodule
